dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the core load/store path and a debug/loader requester.
//  Sits between the ALU/StoreBlock outputs and DataMem.
//  Stalls the core (PC hold, RegWEn gate) in any cycle the debug port owns memory.
//  Bounds debug starvation with a core-streak limit and counts core stall cycles.
// PARAMETERS
//  ADDR_W      32  address width, byte address, word-aligned accesses only
//  DATA_W      32  data width
//  MAX_STREAK  4   consecutive core grants allowed while debug waits; 0 = debug always wins
//  CNT_W       16  width of stall counter
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous reset, active-high
//  core_req    in   1       core accesses memory this cycle (load or store)
//  core_we     in   1       core store
//  core_addr   in   ADDR_W  core address
//  core_wdata  in   DATA_W  store word, already byte-merged
//  core_rdata  out  DATA_W  memory read data to Load/Store blocks
//  core_stall  out  1       hold PC and suppress RegWEn/MemW this cycle
//  dbg_valid   in   1       debug request pending; fields stable until accepted
//  dbg_we      in   1       debug write
//  dbg_addr    in   ADDR_W  debug address
//  dbg_wdata   in   DATA_W  debug write word
//  dbg_ready   out  1       request accepted this cycle
//  dbg_rvalid  out  1       one-cycle pulse, read data valid
//  dbg_rdata   out  DATA_W  registered read data
//  mem_addr    out  ADDR_W  to DataMem Address
//  mem_wdata   out  DATA_W  to DataMem Wdata
//  mem_we      out  1       to DataMem MemRW (GPIO gating stays downstream)
//  mem_rdata   in   DATA_W  from DataMem Rdata, combinational read
//  stall_cnt   out  CNT_W   saturating count of core_stall cycles
// BEHAVIOUR
//  Grant (combinational from inputs and registered streak):
//  - gnt_dbg = !rst && dbg_valid && (!core_req || streak == MAX_STREAK).
//  - gnt_core = !rst && core_req && !gnt_dbg.
//  Outputs per cycle:
//  - dbg_ready = gnt_dbg.
//  - core_stall = core_req && gnt_dbg.
//  - mem_we = (gnt_core && core_we) || (gnt_dbg && dbg_we); 0 when no grant.
//  - mem_addr/mem_wdata: the granted requester's fields, else the core's fields.
//  - core_rdata = mem_rdata always, 0-latency, for store read-modify-write.
//  Writes commit at the clk edge ending the grant cycle.
//  Debug read: mem_rdata captured into dbg_rdata at the grant-cycle edge; dbg_rvalid=1 the next cycle only.
//  dbg_rdata holds its value until the next debug read.
//  Streak register, 0..MAX_STREAK, evaluated at each edge:
//  - dbg granted or !dbg_valid -> 0.
//  - else core granted -> +1, saturating at MAX_STREAK.
//  - else -> hold.
//  stall_cnt: +1 per core_stall cycle, saturating at all-ones, never wraps.
//  Reset (async):
//  - dbg_rvalid=0, dbg_rdata=0, streak=0, stall_cnt=0.
//  - While rst=1: mem_we=0, dbg_ready=0, core_stall=0.
//  - Reset during a debug read drops the pending rvalid.
//  Boundaries:
//  - Both idle -> mem_we=0, no state change except streak=0.
//  - Debug back-to-back with core idle -> one grant per cycle, full throughput.
//  - MAX_STREAK=0 -> core stalls whenever dbg_valid=1.
//  - Unaligned addresses are passed through unchanged; not checked here.
// STRUCTURE
//  Shared package dmem_pkg:
//  - ADDR_W, DATA_W.
//  - GNT_NONE/GNT_CORE/GNT_DBG 2-bit grant encoding.
//  - DBG_RD/DBG_WR opcodes.
//  One sub-module, sat_counter (WIDTH, MAX), instantiated for streak and stall_cnt.
// TESTING
//  1. Core-only: store 0x1234_5678 @0x40, then load @0x40 -> mem_we 1 cycle, core_rdata=0x1234_5678, core_stall never 1.
//  2. Debug-only read @0x40 -> dbg_ready same cycle, dbg_rvalid next cycle, dbg_rdata=0x1234_5678.
//  3. MAX_STREAK=4, core_req and dbg_valid held high -> core granted 4 cycles, stalled on 5th, pattern repeats; stall_cnt=1 per 5 cycles.
//  4. Same cycle: dbg write 0xDEAD_BEEF @0x80 (wins at streak max), core load @0x80 -> core stalled; core re-issues next cycle and reads 0xDEAD_BEEF.
//  5. Assert rst in the cycle after a debug read grant -> dbg_rvalid stays 0, mem_we=0, stall_cnt=0.
//  6. Force 2^CNT_W+3 stall cycles -> stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory arbiter slice.
//   - ADDR_W / DATA_W : default address and data widths for the data memory.
//   - gnt_e           : 2-bit encoding of which requester owns memory this cycle.
//   - dbg_op_e        : debug port operation, decoded from dbg_we.
//   - streak_width()  : bits needed to hold a core-streak count of 0..max.
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_CORE = 2'b01,
    GNT_DBG  = 2'b10
  } gnt_e;

  typedef enum logic {
    DBG_RD = 1'b0,
    DBG_WR = 1'b1
  } dbg_op_e;

  // A zero-length streak still needs a one-bit register so the counter
  // instance stays legal; it simply never leaves zero.
  function automatic int streak_width(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that clears on request and stops at a fixed ceiling instead of
//   wrapping. Used for the core-streak register and the stall-cycle counter.
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous reset, active-high, count -> 0
//   clr    in   1      synchronous clear, has priority over inc
//   inc    in   1      add one this edge unless already at MAX
//   count  out  WIDTH  current count, 0..MAX
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: state registers use non-blocking assignments and list the reset in
  // the sensitivity list so reset acts without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the core load/store path and a
//   debug/loader requester. The core normally wins; a waiting debug request is
//   served once the core has been granted MAX_STREAK cycles in a row (or at
//   once when the core is idle). Whenever the debug port owns memory while the
//   core also wants it, the core is stalled (PC hold, RegWEn/MemW gated).
// Ports
//   clk, rst                  clock (rising edge), async reset (active-high)
//   core_req/we/addr/wdata    core access request, store word pre-merged
//   core_rdata                memory read data, zero latency pass-through
//   core_stall                core lost arbitration this cycle
//   dbg_valid/we/addr/wdata   debug request, held stable until dbg_ready
//   dbg_ready                 debug request accepted this cycle
//   dbg_rvalid/dbg_rdata      registered debug read result, one-cycle pulse
//   mem_addr/wdata/we         to the data memory
//   mem_rdata                 from the data memory, combinational read
//   stall_cnt                 saturating count of core stall cycles
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W     = dmem_pkg::ADDR_W,
  parameter int DATA_W     = dmem_pkg::DATA_W,
  parameter int MAX_STREAK = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  // core load/store path
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  // debug / loader port
  input  logic              dbg_valid,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  // data memory
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  // statistics
  output logic [CNT_W-1:0]  stall_cnt
);

  import dmem_pkg::*;

  localparam int                  STREAK_W   = streak_width(MAX_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  gnt_e                gnt;
  dbg_op_e             dbg_op;
  logic                gnt_dbg;
  logic                gnt_core;
  logic                dbg_rd_gnt;
  logic [STREAK_W-1:0] streak;

  assign dbg_op = dbg_we ? DBG_WR : DBG_RD;

  // Grant decision is purely combinational so the requester is served in the
  // same cycle it asks. Reset forces GNT_NONE so nothing is written while the
  // memory contents and the system around it are undefined.
  // NOTE: gnt gets a default before any branch so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (dbg_valid && (!core_req || (streak == STREAK_MAX))) begin
        gnt = GNT_DBG;
      end else if (core_req) begin
        gnt = GNT_CORE;
      end
    end
  end

  assign gnt_dbg    = (gnt == GNT_DBG);
  assign gnt_core   = (gnt == GNT_CORE);
  assign dbg_rd_gnt = gnt_dbg && (dbg_op == DBG_RD);

  assign dbg_ready  = gnt_dbg;
  assign core_stall = core_req && gnt_dbg;

  // Address and data follow the owner; with no owner they default to the core
  // fields, which is harmless because mem_we is low.
  assign mem_we    = (gnt_core && core_we) || (gnt_dbg && (dbg_op == DBG_WR));
  assign mem_addr  = gnt_dbg ? dbg_addr  : core_addr;
  assign mem_wdata = gnt_dbg ? dbg_wdata : core_wdata;

  // The core sees the memory output unconditionally; the store path needs it
  // in the same cycle for read-modify-write byte merging.
  assign core_rdata = mem_rdata;

  // Debug read data is captured at the end of the grant cycle and held until
  // the next debug read, with a single-cycle valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbg_rd_gnt;
      if (dbg_rd_gnt) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

  // Consecutive core grants while debug is waiting. Any debug grant, or the
  // debug side going idle, restarts the count.
  sat_counter #(
    .WIDTH (STREAK_W),
    .MAX   (STREAK_MAX)
  ) u_streak (
    .clk   (clk),
    .rst   (rst),
    .clr   (gnt_dbg || !dbg_valid),
    .inc   (gnt_core),
    .count (streak)
  );

  // Stall cycles seen by the core; sticks at all-ones rather than wrapping.
  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   ({CNT_W{1'b1}})
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (core_stall),
    .count (stall_cnt)
  );

endmodule
